// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-stage controller between the EX/MEM latch and the
// data cache. Loads and stores are captured and then held on the cache
// interface until dhit. Non-memory instructions are forwarded straight to the
// registered MEM/WB outputs. Branch resolution is combinational.
//
// Optional feature: define MEM_LUI_MERGE_EN to have a valid lUI write
// {imm_lui, 16'h0000} instead of alu_out.
//
// Handshake: the upstream stage presents an instruction with ex_valid=1 and
// must hold every EX/MEM input stable while mem_busy=1. An instruction is
// consumed on the first rising edge where ex_valid=1 and mem_busy=0. A memory
// operation is the exception: it is consumed on the edge that takes IDLE to
// ACCESS, even though mem_busy is high in that cycle. On the cache side,
// dmemREN/dmemWEN act as a request valid. The request, dmemaddr and dmemstore
// stay constant until dhit=1 is sampled on a rising edge, which completes it.
module mem_stage_ctrl (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ex_valid,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic        bNE,
  input  logic        bEQ,
  input  logic        jAL,
  input  logic        flagZero,
  input  logic        lUI,
  input  logic [31:0] pcplusfour,
  input  logic [31:0] rdat2,
  input  logic [31:0] branch_addr,
  input  logic [31:0] alu_out,
  input  logic [4:0]  dest_reg,
  input  logic [15:0] imm_lui,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  output logic        mem_busy,
  output logic        branch_taken,
  output logic [31:0] branch_target,
  output logic        wb_valid,
  output logic        wb_wen,
  output logic [4:0]  wb_dest,
  output logic [31:0] wb_data,
  output logic        dbgState
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t      state;
  logic [31:0] capAddr;
  logic [31:0] capStore;
  logic [4:0]  capDest;
  logic        capIsStore;
  logic        memOp;

  assign memOp         = dREN | dWEN;
  assign dmemaddr      = capAddr;
  assign dmemstore     = capStore;
  assign branch_target = branch_addr;
  assign dbgState      = (state == ACCESS);

  // Stall upstream while a memory op is being accepted or is still waiting on the cache
  assign mem_busy = ((state == IDLE) & ex_valid & memOp) |
                    ((state == ACCESS) & ~dhit);

  // Branch outcome is resolved only for instructions seen in IDLE
  assign branch_taken = (state == IDLE) & ex_valid &
                        ((bEQ & flagZero) | (bNE & ~flagZero));

`ifndef MEM_LUI_MERGE_EN
  // lUI and imm_lui are deliberately unused when the LUI merge is disabled
  logic unusedLui;
  assign unusedLui = ^{lUI, imm_lui};
`endif

  // Controller FSM: capture, cache access and MEM/WB register update
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      dmemREN    <= 1'b0;
      dmemWEN    <= 1'b0;
      capAddr    <= '0;
      capStore   <= '0;
      capDest    <= '0;
      capIsStore <= 1'b0;
      wb_valid   <= 1'b0;
      wb_wen     <= 1'b0;
      wb_dest    <= '0;
      wb_data    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (ex_valid && memOp) begin
            // A store wins when both request bits are set
            state      <= ACCESS;
            capAddr    <= alu_out;
            capStore   <= rdat2;
            capDest    <= dest_reg;
            capIsStore <= dWEN;
            dmemREN    <= dREN & ~dWEN;
            dmemWEN    <= dWEN;
            wb_valid   <= 1'b0;
            wb_wen     <= 1'b0;
          end else if (ex_valid) begin
            wb_valid <= 1'b1;
            if (jAL) begin
              wb_wen  <= 1'b1;
              wb_dest <= 5'd31;
              wb_data <= pcplusfour;
            end else if (bEQ || bNE) begin
              wb_wen  <= 1'b0;
              wb_dest <= dest_reg;
              wb_data <= alu_out;
`ifdef MEM_LUI_MERGE_EN
            end else if (lUI) begin
              wb_wen  <= 1'b1;
              wb_dest <= dest_reg;
              wb_data <= {imm_lui, 16'h0000};
`endif
            end else begin
              wb_wen  <= 1'b1;
              wb_dest <= dest_reg;
              wb_data <= alu_out;
            end
          end else begin
            wb_valid <= 1'b0;
            wb_wen   <= 1'b0;
          end
        end
        ACCESS: begin
          if (dhit) begin
            state    <= IDLE;
            dmemREN  <= 1'b0;
            dmemWEN  <= 1'b0;
            wb_valid <= 1'b1;
            wb_wen   <= ~capIsStore;
            wb_dest  <= capDest;
            wb_data  <= capIsStore ? capStore : dmemload;
          end else begin
            wb_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// tb_mem_stage_ctrl: directed bench for mem_stage_ctrl. Inputs change and
// outputs are sampled around the falling edge. A writeback scoreboard pops one
// expected {wen, dest, data} entry for every cycle in which wb_valid is high.
module tb_mem_stage_ctrl;

  logic        CLK, RST;
  logic        ex_valid, dREN, dWEN, bNE, bEQ, jAL, flagZero, lUI;
  logic [31:0] pcplusfour, rdat2, branch_addr, alu_out;
  logic [4:0]  dest_reg;
  logic [15:0] imm_lui;
  logic        dhit;
  logic [31:0] dmemload;
  logic        dmemREN, dmemWEN;
  logic [31:0] dmemaddr, dmemstore;
  logic        mem_busy, branch_taken;
  logic [31:0] branch_target;
  logic        wb_valid, wb_wen;
  logic [4:0]  wb_dest;
  logic [31:0] wb_data;
  logic        dbgState;

  int tests = 0;
  int failed = 0;
  logic [37:0] exp_q[$];
  logic [37:0] sb_e;

  mem_stage_ctrl dut (
    .CLK(CLK), .RST(RST), .ex_valid(ex_valid), .dREN(dREN), .dWEN(dWEN),
    .bNE(bNE), .bEQ(bEQ), .jAL(jAL), .flagZero(flagZero), .lUI(lUI),
    .pcplusfour(pcplusfour), .rdat2(rdat2), .branch_addr(branch_addr),
    .alu_out(alu_out), .dest_reg(dest_reg), .imm_lui(imm_lui), .dhit(dhit),
    .dmemload(dmemload), .dmemREN(dmemREN), .dmemWEN(dmemWEN),
    .dmemaddr(dmemaddr), .dmemstore(dmemstore), .mem_busy(mem_busy),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .wb_valid(wb_valid), .wb_wen(wb_wen), .wb_dest(wb_dest),
    .wb_data(wb_data), .dbgState(dbgState)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  initial RST = 1'b1;

  // Writeback scoreboard
  always @(negedge CLK) begin
    if (wb_valid === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL sb_unexpected_wb: got wen=%b dest=%0d data=%h, required no writeback",
                 wb_wen, wb_dest, wb_data);
      end else begin
        sb_e = exp_q.pop_front();
        if (wb_wen !== sb_e[37] || (sb_e[37] && ({wb_dest, wb_data} !== sb_e[36:0]))) begin
          failed++;
          $display("FAIL sb_wb: got wen=%b dest=%0d data=%h, required wen=%b dest=%0d data=%h",
                   wb_wen, wb_dest, wb_data, sb_e[37], sb_e[36:32], sb_e[31:0]);
        end
      end
    end
  end

  // Drivers
  task automatic drive_idle();
    ex_valid = 0; dREN = 0; dWEN = 0; bNE = 0; bEQ = 0; jAL = 0;
    flagZero = 0; lUI = 0; dhit = 0;
  endtask

  task automatic drive_zero_data();
    pcplusfour = 0; rdat2 = 0; branch_addr = 0; alu_out = 0;
    dest_reg = 0; imm_lui = 0; dmemload = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    drive_zero_data();
    @(negedge CLK);
    tests++;
    if ({dmemREN, dmemWEN, wb_valid, wb_wen, dbgState, mem_busy} !== 6'b0) begin
      failed++;
      $display("FAIL reset_ctrl: got REN=%b WEN=%b wbv=%b wen=%b st=%b busy=%b, required all 0",
               dmemREN, dmemWEN, wb_valid, wb_wen, dbgState, mem_busy);
    end
    tests++;
    if ({wb_dest, wb_data, dmemaddr, dmemstore} !== 101'b0) begin
      failed++;
      $display("FAIL reset_data: got dest=%0d data=%h addr=%h store=%h, required all 0",
               wb_dest, wb_data, dmemaddr, dmemstore);
    end
    // Instruction accepted on the first edge after release
    RST = 0;
    ex_valid = 1; alu_out = 32'h11; dest_reg = 5'd2;
    exp_q.push_back({1'b1, 5'd2, 32'h11});
    @(negedge CLK);
    drive_idle();
    #1;
    tests++;
    if (wb_valid !== 1'b1 || wb_data !== 32'h11) begin
      failed++;
      $display("FAIL first_edge_accept: got wbv=%b data=%h, required 1 00000011", wb_valid, wb_data);
    end
    @(negedge CLK);
    #1;
    tests++;
    if (wb_valid !== 1'b0 || wb_wen !== 1'b0) begin
      failed++;
      $display("FAIL invalid_clears_wb: got wbv=%b wen=%b, required 0 0", wb_valid, wb_wen);
    end
  endtask

  task automatic test_load();
    ex_valid = 1; dREN = 1; alu_out = 32'h40; rdat2 = 0; dest_reg = 5'd5; dmemload = 0;
    exp_q.push_back({1'b1, 5'd5, 32'hDEAD_BEEF});
    #1;
    tests++;
    if (mem_busy !== 1'b1 || dmemREN !== 1'b0) begin
      failed++;
      $display("FAIL load_accept: got busy=%b REN=%b, required 1 0", mem_busy, dmemREN);
    end
    for (int i = 1; i <= 3; i++) begin
      @(negedge CLK);
      if (i == 2) begin
        alu_out = 32'h99; bEQ = 1; flagZero = 1;
      end
      if (i == 3) begin
        alu_out = 32'h40; bEQ = 0; flagZero = 0; dhit = 1; dmemload = 32'hDEAD_BEEF;
      end
      #1;
      tests++;
      if (dmemREN !== 1'b1 || dmemWEN !== 1'b0 || dmemaddr !== 32'h40 ||
          mem_busy !== (i != 3) || branch_taken !== 1'b0 || wb_valid !== 1'b0) begin
        failed++;
        $display("FAIL load_access_%0d: got REN=%b WEN=%b addr=%h busy=%b bt=%b wbv=%b, required 1 0 00000040 %b 0 0",
                 i, dmemREN, dmemWEN, dmemaddr, mem_busy, branch_taken, wb_valid, (i != 3));
      end
    end
    @(negedge CLK);
    drive_idle();
    #1;
    tests++;
    if (wb_valid !== 1'b1 || wb_wen !== 1'b1 || wb_dest !== 5'd5 ||
        wb_data !== 32'hDEAD_BEEF || dmemREN !== 1'b0 || mem_busy !== 1'b0) begin
      failed++;
      $display("FAIL load_wb: got wbv=%b wen=%b dest=%0d data=%h REN=%b busy=%b, required 1 1 5 deadbeef 0 0",
               wb_valid, wb_wen, wb_dest, wb_data, dmemREN, mem_busy);
    end
    @(negedge CLK);
    #1;
    tests++;
    if (wb_valid !== 1'b0) begin
      failed++;
      $display("FAIL load_wb_pulse: got wbv=%b, required 0", wb_valid);
    end
  endtask

  task automatic test_store();
    logic [31:0] addr, data;
    for (int k = 0; k < 2; k++) begin
      addr = (k == 0) ? 32'h80 : 32'h84;
      data = (k == 0) ? 32'h1234_5678 : 32'hCAFE_F00D;
      ex_valid = 1; dWEN = 1; dREN = (k == 1); alu_out = addr; rdat2 = data; dest_reg = 5'd6;
      exp_q.push_back({1'b0, 5'd6, data});
      #1;
      tests++;
      if (mem_busy !== 1'b1) begin
        failed++;
        $display("FAIL store_accept_%0d: got busy=%b, required 1", k, mem_busy);
      end
      @(negedge CLK);
      dhit = 1; dmemload = 32'h0BAD_0BAD;
      #1;
      tests++;
      if (dmemWEN !== 1'b1 || dmemREN !== 1'b0 || dmemaddr !== addr ||
          dmemstore !== data || mem_busy !== 1'b0) begin
        failed++;
        $display("FAIL store_access_%0d: got WEN=%b REN=%b addr=%h store=%h busy=%b, required 1 0 %h %h 0",
                 k, dmemWEN, dmemREN, dmemaddr, dmemstore, mem_busy, addr, data);
      end
      @(negedge CLK);
      drive_idle();
      #1;
      tests++;
      if (wb_valid !== 1'b1 || wb_wen !== 1'b0 || dmemWEN !== 1'b0) begin
        failed++;
        $display("FAIL store_wb_%0d: got wbv=%b wen=%b WEN=%b, required 1 0 0", k, wb_valid, wb_wen, dmemWEN);
      end
      @(negedge CLK);
      #1;
      tests++;
      if (wb_valid !== 1'b0 || dmemWEN !== 1'b0) begin
        failed++;
        $display("FAIL store_done_%0d: got wbv=%b WEN=%b, required 0 0", k, wb_valid, dmemWEN);
      end
    end
  endtask

  task automatic test_branch();
    ex_valid = 1; bEQ = 1; flagZero = 1; branch_addr = 32'h100; alu_out = 0; dest_reg = 0;
    #1;
    tests++;
    if (branch_taken !== 1'b1 || branch_target !== 32'h100 || mem_busy !== 1'b0) begin
      failed++;
      $display("FAIL beq_taken: got bt=%b target=%h busy=%b, required 1 00000100 0",
               branch_taken, branch_target, mem_busy);
    end
    bEQ = 0; bNE = 1;
    #1;
    tests++;
    if (branch_taken !== 1'b0) begin
      failed++;
      $display("FAIL bne_not_taken: got bt=%b, required 0", branch_taken);
    end
    flagZero = 0;
    #1;
    tests++;
    if (branch_taken !== 1'b1) begin
      failed++;
      $display("FAIL bne_taken: got bt=%b, required 1", branch_taken);
    end
    exp_q.push_back({1'b0, 5'd0, 32'h0});
    @(negedge CLK);
    drive_idle();
    bNE = 1;
    #1;
    tests++;
    if (wb_valid !== 1'b1 || wb_wen !== 1'b0 || branch_taken !== 1'b0) begin
      failed++;
      $display("FAIL branch_wb: got wbv=%b wen=%b bt=%b, required 1 0 0", wb_valid, wb_wen, branch_taken);
    end
    drive_idle();
    @(negedge CLK);
  endtask

  task automatic test_jal();
    ex_valid = 1; jAL = 1; pcplusfour = 32'h204; dest_reg = 5'd3; alu_out = 32'h55;
    exp_q.push_back({1'b1, 5'd31, 32'h204});
    @(negedge CLK);
    drive_idle();
    #1;
    tests++;
    if (wb_valid !== 1'b1 || wb_wen !== 1'b1 || wb_dest !== 5'd31 || wb_data !== 32'h204) begin
      failed++;
      $display("FAIL jal_wb: got wbv=%b wen=%b dest=%0d data=%h, required 1 1 31 00000204",
               wb_valid, wb_wen, wb_dest, wb_data);
    end
    @(negedge CLK);
  endtask

  task automatic test_back_to_back();
    logic [31:0] lui_exp;
`ifdef MEM_LUI_MERGE_EN
    lui_exp = 32'hABCD_0000;
`else
    lui_exp = 32'h0000_0005;
`endif
    ex_valid = 1; alu_out = 32'h77; dest_reg = 5'd7;
    exp_q.push_back({1'b1, 5'd7, 32'h77});
    @(negedge CLK);
    lUI = 1; imm_lui = 16'hABCD; alu_out = 32'h5; dest_reg = 5'd9;
    exp_q.push_back({1'b1, 5'd9, lui_exp});
    #1;
    tests++;
    if (wb_valid !== 1'b1 || wb_wen !== 1'b1 || wb_dest !== 5'd7 || wb_data !== 32'h77) begin
      failed++;
      $display("FAIL alu_wb: got wbv=%b wen=%b dest=%0d data=%h, required 1 1 7 00000077",
               wb_valid, wb_wen, wb_dest, wb_data);
    end
    @(negedge CLK);
    drive_idle();
    #1;
    tests++;
    if (wb_valid !== 1'b1 || wb_dest !== 5'd9 || wb_data !== lui_exp) begin
      failed++;
      $display("FAIL lui_wb: got wbv=%b dest=%0d data=%h, required 1 9 %h", wb_valid, wb_dest, wb_data, lui_exp);
    end
    @(negedge CLK);
    #1;
    tests++;
    if (wb_valid !== 1'b0 || wb_wen !== 1'b0) begin
      failed++;
      $display("FAIL idle_after_b2b: got wbv=%b wen=%b, required 0 0", wb_valid, wb_wen);
    end
  endtask

  task automatic test_reset_mid_access();
    ex_valid = 1; dREN = 1; alu_out = 32'h200; dest_reg = 5'd4;
    @(negedge CLK);
    #1;
    tests++;
    if (dmemREN !== 1'b1 || dbgState !== 1'b1) begin
      failed++;
      $display("FAIL rst_mid_pre: got REN=%b st=%b, required 1 1", dmemREN, dbgState);
    end
    #2;
    RST = 1;
    #1;
    tests++;
    if (dmemREN !== 1'b0 || dbgState !== 1'b0 || dmemaddr !== 32'h0 || wb_valid !== 1'b0) begin
      failed++;
      $display("FAIL rst_mid_async: got REN=%b st=%b addr=%h wbv=%b, required 0 0 00000000 0",
               dmemREN, dbgState, dmemaddr, wb_valid);
    end
    drive_idle();
    @(negedge CLK);
    RST = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      #1;
      tests++;
      if (wb_valid !== 1'b0 || dmemREN !== 1'b0) begin
        failed++;
        $display("FAIL rst_mid_no_wb_%0d: got wbv=%b REN=%b, required 0 0", i, wb_valid, dmemREN);
      end
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_store();
    test_branch();
    test_jal();
    test_back_to_back();
    test_reset_mid_access();
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL sb_missing_wb: got %0d writebacks outstanding, required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mem_stage_ctrl.md
MEM_STAGE_CTRL -- requirements
Module: mem_stage_ctrl

Interface
REQ-001 The block SHALL have one clock, CLK (input, 1): rising edge.
REQ-002 The block SHALL have one reset, RST (input, 1): asynchronous, active-high.
REQ-003 The block SHALL have the following EX/MEM-side inputs, each driven from the EX/MEM latch outputs:
- ex_valid (1): EX/MEM slot holds a live instruction.
- dREN, dWEN (1 each): load and store requests.
- bNE, bEQ (1 each): branch type.
- jAL (1): jump-and-link.
- flagZero (1): ALU zero flag.
- lUI (1): load-upper-immediate.
REQ-004 The block SHALL have the following EX/MEM-side data inputs:
- pcplusfour, rdat2, branch_addr, alu_out (32 each).
- dest_reg (5).
- imm_lui (16).
REQ-005 The block SHALL have the following cache-side ports:
- dhit (input, 1).
- dmemload (input, 32).
- dmemREN, dmemWEN (output, 1 each).
- dmemaddr, dmemstore (output, 32 each).
REQ-006 The block SHALL have the following control outputs:
- mem_busy (1): stall upstream.
- branch_taken (1).
- branch_target (32).
REQ-007 The block SHALL have the following MEM/WB outputs, all registered:
- wb_valid (1).
- wb_wen (1).
- wb_dest (5).
- wb_data (32).

Function
REQ-008 The block SHALL implement a two-state FSM, IDLE and ACCESS.
REQ-009 In IDLE with ex_valid=1 and (dREN|dWEN)=1, the block SHALL capture alu_out, rdat2, dest_reg and op type into internal registers and SHALL move to ACCESS on the next edge.
REQ-010 dmemREN/dmemWEN SHALL be asserted only in ACCESS, decoded from the captured op. dmemaddr SHALL equal the captured alu_out and dmemstore the captured rdat2. Both SHALL stay stable until dhit.
REQ-011 In ACCESS, the block SHALL remain in ACCESS while dhit=0 and SHALL return to IDLE on the edge where dhit=1, capturing dmemload for loads on that edge.
REQ-012 mem_busy SHALL be the combinational OR of two terms:
- (IDLE & ex_valid & (dREN|dWEN)).
- (ACCESS & !dhit).
The upstream stage holds EX/MEM inputs stable while mem_busy=1.
REQ-013 For a memory operation, the block SHALL pulse wb_valid=1 for exactly one cycle, on the cycle after the dhit edge. The minimum load/store latency from acceptance to wb_valid SHALL be 2 cycles.
REQ-014 For a non-memory valid instruction in IDLE, wb_* SHALL update on the next edge (1-cycle latency).
REQ-015 A load SHALL produce wb_wen=1, wb_data=dmemload and wb_dest=captured dest_reg.
REQ-016 A store SHALL produce wb_wen=0.
REQ-017 A jAL SHALL produce wb_wen=1, wb_data=pcplusfour and wb_dest=31.
REQ-018 A branch (bEQ or bNE) SHALL produce wb_wen=0.
REQ-019 Any other valid instruction SHALL produce wb_wen=1, wb_data=alu_out and wb_dest=dest_reg.
REQ-020 branch_taken SHALL equal IDLE & ex_valid & ((bEQ & flagZero) | (bNE & !flagZero)), combinationally. branch_target SHALL equal branch_addr at all times.
REQ-021 If dREN and dWEN are both 1, the block SHALL perform the store only (dWEN priority).
REQ-022 With ex_valid=0 in IDLE, the block SHALL drive wb_valid=0 and wb_wen=0 on the next edge.
REQ-023 The block SHALL ignore new inputs while in ACCESS, with no capture and no branch_taken.
REQ-024 If dhit arrives in the same cycle ACCESS is entered, the block SHALL honour it in that cycle.

Reset
REQ-025 On RST=1, the following SHALL occur immediately, independent of CLK:
- state=IDLE.
- dmemREN=0, dmemWEN=0.
- wb_valid=0, wb_wen=0, wb_dest=0, wb_data=0.
- all internal capture registers=0.
REQ-026 Reset asserted during ACCESS SHALL abandon the pending access with no writeback.
REQ-027 After RST deasserts, the block SHALL accept an instruction on the first rising edge.

Configuration
REQ-028 The macro MEM_LUI_MERGE_EN SHALL control LUI writeback, as follows:
- Defined: a valid lUI instruction SHALL write wb_data={imm_lui,16'h0000}, ignoring alu_out.
- Undefined: lUI SHALL be ignored by this block, and wb_data=alu_out.

Verification
REQ-029 Reset then load: alu_out=32'h0000_0040, dREN=1, dest_reg=5, dhit high on the 3rd ACCESS cycle, dmemload=32'hDEAD_BEEF -> the bench SHALL observe all of the following:
- dmemREN high for 3 cycles with dmemaddr=0x40.
- mem_busy high until dhit.
- wb_valid pulse with wb_data=0xDEADBEEF and wb_dest=5.
REQ-030 Store with immediate dhit: alu_out=0x80, rdat2=0x1234_5678 -> the bench SHALL observe all of the following:
- dmemWEN for exactly 1 cycle, with dmemstore=0x12345678.
- wb_valid 2 cycles after acceptance.
- wb_wen=0.
REQ-031 Branch: bEQ=1, flagZero=1, branch_addr=0x100 -> the bench SHALL observe branch_taken=1 and branch_target=0x100 in the same cycle. With bNE=1 and flagZero=1 instead, the bench SHALL observe branch_taken=0.
REQ-032 jAL with pcplusfour=0x204 -> the bench SHALL observe wb_dest=31, wb_data=0x204 and wb_wen=1 one cycle later.
REQ-033 Reset mid-access: assert RST in ACCESS with dhit=0 -> the bench SHALL observe dmemREN=0 immediately and no wb_valid after release.
REQ-034 lUI=1 with imm_lui=0xABCD and alu_out=0x5 -> the bench SHALL observe wb_data=0xABCD0000 with MEM_LUI_MERGE_EN defined, and wb_data=0x5 without it.
